bellek_hakemi: RTL and testbench
================================

Name: bellek_hakemi

Overview:
- Arbitrates the single shared main-memory port between the instruction-fetch requester (getir) and the load/store requester (veri) of the multicycle RV32 core.
- Sits between the core's control FSM and the main memory.
- Handles valid/ready request handshakes, address range and alignment checking, write-strobe generation and one-cycle response pulses.
- Includes a starvation guard so fetch is never locked out by back-to-back data accesses.

Parameters:
- VERI_BIT, 32, data width.
- ADRES_BIT, 32, address width.
- BELLEK_ADRES, 32'h8000_0000, base byte address of main memory.
- BELLEK_BOYUT, 32'h0000_4000, memory size in bytes (power of two).
- ACLIK_SINIRI, 4, max consecutive veri grants while getir waits.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- getir_istek  in  1  fetch request valid.
- getir_adres  in  ADRES_BIT  fetch byte address.
- getir_hazir  out  1  fetch request accepted this cycle.
- getir_gecerli  out  1  fetch response valid (1-cycle pulse).
- getir_veri  out  VERI_BIT  fetched word.
- getir_hata  out  1  fetch was out of range or misaligned.
- veri_istek  in  1  load/store request valid.
- veri_yaz  in  1  1 = store, 0 = load.
- veri_adres  in  ADRES_BIT  load/store byte address.
- veri_yaz_veri  in  VERI_BIT  store data.
- veri_hazir  out  1  load/store request accepted this cycle.
- veri_gecerli  out  1  load/store response valid (1-cycle pulse; stores are acknowledged too).
- veri_oku_veri  out  VERI_BIT  loaded word (0 for stores).
- veri_hata  out  1  load/store was out of range or misaligned.
- bellek_adres  out  ADRES_BIT  memory address (registered).
- bellek_oku_veri  in  VERI_BIT  memory read data, combinational from bellek_adres.
- bellek_yaz_veri  out  VERI_BIT  memory write data (registered).
- bellek_yaz  out  1  memory write enable; memory writes on the posedge ending the cycle.

Behaviour:
- **States:** BOSTA, ERISIM, YANIT.
  - BOSTA -> ERISIM on acceptance.
  - ERISIM -> YANIT always.
  - YANIT -> ERISIM on acceptance, else -> BOSTA.
- **Acceptance:**
  - Possible only in BOSTA or YANIT.
  - hazir is combinational: state in {BOSTA, YANIT}, the requester's istek is 1, and the requester holds the grant.
  - At most one hazir per cycle; hazir is never asserted in ERISIM.
  - A requester holds istek, adres, yaz and yaz_veri stable until its hazir is seen.
- **Grant priority:**
  - veri wins over getir by default.
  - sayac counts consecutive veri grants made while getir_istek=1. It resets to 0 on any getir grant, or on a veri grant with getir_istek=0.
  - When sayac == ACLIK_SINIRI, getir wins the next contested acceptance.
- **Accept edge:**
  - Latch the requester id, yaz and hata.
  - bellek_adres <= address.
  - bellek_yaz_veri <= store data.
  - bellek_yaz <= yaz & ~hata.
- **hata condition:** hata = adres < BELLEK_ADRES, or adres >= BELLEK_ADRES+BELLEK_BOYUT, or adres[1:0] != 0.
  - A hata access never asserts bellek_yaz.
  - A hata access returns data 0.
- **ERISIM cycle:**
  - bellek_yaz is high only for a valid store; it is exactly one cycle wide.
  - The response data register captures bellek_oku_veri for a valid load; otherwise it captures 0.
  - bellek_yaz clears at the end of ERISIM.
- **YANIT cycle:**
  - The owning requester's gecerli=1, with veri/hata held from the registers.
  - The other requester's gecerli=0.
  - Response data stays stable until the next response.
- **Latency:** request accepted at edge N gives gecerli during cycle N+1..N+2, i.e. the second cycle after the hazir cycle.
  - Back-to-back throughput is 1 access per 2 cycles.
- **Idle:** bellek_adres holds its last value and bellek_yaz=0.
- **Reset** (rst=1 at a posedge):
  - State BOSTA, sayac 0.
  - All hazir/gecerli/hata outputs = 0; data outputs = 0.
  - bellek_adres = BELLEK_ADRES; bellek_yaz_veri = 0.
  - The bellek_yaz output port is gated combinationally by ~rst, so a store in flight during a reset cycle is not written.
  - No response is issued for a transaction aborted by reset.
- **Simultaneous istek in the YANIT cycle:** the new grant follows the priority rule; the completing response pulse is unaffected.

Test Plan:
1. Reset then getir_istek, adres 8000_0000, memory word 0000_0013: getir_hazir in the same cycle; bellek_adres=8000_0000 next cycle; getir_gecerli=1, getir_veri=0000_0013 two cycles after hazir; veri_gecerli stays 0.
2. Store 8000_0100 <- DEAD_BEEF, then load 8000_0100: bellek_yaz high exactly 1 cycle; veri_gecerli on both; load returns DEAD_BEEF, veri_hata=0.
3. getir_istek and veri_istek held continuously: grant order is veri ×4, getir, veri ×4, getir...; no two hazir in one cycle; a response every 2 cycles.
4. Store to 8000_0102 (misaligned) and load from 7FFF_FFFC (below base): bellek_yaz never high; veri_gecerli with veri_hata=1, veri_oku_veri=0.
5. Store accepted, rst=1 during its ERISIM cycle: bellek_yaz port stays 0; memory unchanged; no veri_gecerli; bellek_adres=8000_0000 after reset.
6. Load accepted while a fetch is waiting: fetch gets hazir in the YANIT cycle of the load; the load response pulse still occurs in that cycle; back-to-back timing holds.

Source files
------------

// File: rtl/bellek_hakemi_if.sv
// Request/response and memory-port bundle between the core, the arbiter and main memory.
// The arbiter takes the slave side; the core/memory model takes the master side.
interface bellek_hakemi_if #(
  parameter int unsigned VERI_BIT  = 32,
  parameter int unsigned ADRES_BIT = 32
);
  logic                 getir_istek;
  logic [ADRES_BIT-1:0] getir_adres;
  logic                 getir_hazir;
  logic                 getir_gecerli;
  logic [VERI_BIT-1:0]  getir_veri;
  logic                 getir_hata;

  logic                 veri_istek;
  logic                 veri_yaz;
  logic [ADRES_BIT-1:0] veri_adres;
  logic [VERI_BIT-1:0]  veri_yaz_veri;
  logic                 veri_hazir;
  logic                 veri_gecerli;
  logic [VERI_BIT-1:0]  veri_oku_veri;
  logic                 veri_hata;

  logic [ADRES_BIT-1:0] bellek_adres;
  logic [VERI_BIT-1:0]  bellek_oku_veri;
  logic [VERI_BIT-1:0]  bellek_yaz_veri;
  logic                 bellek_yaz;

  modport slave (
    input  getir_istek, getir_adres,
    input  veri_istek, veri_yaz, veri_adres, veri_yaz_veri,
    input  bellek_oku_veri,
    output getir_hazir, getir_gecerli, getir_veri, getir_hata,
    output veri_hazir, veri_gecerli, veri_oku_veri, veri_hata,
    output bellek_adres, bellek_yaz_veri, bellek_yaz
  );

  modport master (
    output getir_istek, getir_adres,
    output veri_istek, veri_yaz, veri_adres, veri_yaz_veri,
    output bellek_oku_veri,
    input  getir_hazir, getir_gecerli, getir_veri, getir_hata,
    input  veri_hazir, veri_gecerli, veri_oku_veri, veri_hata,
    input  bellek_adres, bellek_yaz_veri, bellek_yaz
  );
endinterface

// File: rtl/bellek_hakemi.sv
// Shared main-memory port arbiter for the fetch (getir) and load/store (veri) requesters.
// One access per two cycles: accept -> ERISIM (memory cycle) -> YANIT (response pulse).

module bellek_hakemi_denetim #(
  parameter int unsigned          ADRES_BIT    = 32,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000,
  parameter logic [ADRES_BIT-1:0] BELLEK_BOYUT = 32'h0000_4000
) (
  input  logic [ADRES_BIT-1:0] adres,
  output logic                 hata
);
  // One extra bit so a memory window ending at the top of the address space does not wrap.
  localparam logic [ADRES_BIT:0] ALT = {1'b0, BELLEK_ADRES};
  localparam logic [ADRES_BIT:0] UST = {1'b0, BELLEK_ADRES} + {1'b0, BELLEK_BOYUT};

  logic [ADRES_BIT:0] genis;
  assign genis = {1'b0, adres};
  assign hata  = (genis < ALT) || (genis >= UST) || (adres[1:0] != 2'b00);
endmodule

module bellek_hakemi #(
  parameter int unsigned          VERI_BIT     = 32,
  parameter int unsigned          ADRES_BIT    = 32,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000,
  parameter logic [ADRES_BIT-1:0] BELLEK_BOYUT = 32'h0000_4000,
  parameter int unsigned          ACLIK_SINIRI = 4
) (
  input  logic           clk,
  input  logic           rst,
  bellek_hakemi_if.slave bif
);
  typedef enum logic [1:0] {BOSTA, ERISIM, YANIT} durum_t;

  localparam logic                 GETIR     = 1'b0;
  localparam logic                 VERI      = 1'b1;
  localparam int unsigned          SAYAC_BIT = $clog2(ACLIK_SINIRI + 1);
  localparam logic [SAYAC_BIT-1:0] SINIR     = SAYAC_BIT'(ACLIK_SINIRI);

  typedef struct packed {
    logic                 yaz;
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BIT-1:0]  yaz_veri;
  } istek_t;

  durum_t                        durum, durum_sonraki;
  logic [SAYAC_BIT-1:0]          sayac, sayac_sonraki;
  logic [1:0]                    istek, hazir, hata;
  istek_t [1:0]                  talep;
  logic                          sahip, kabul;

  logic                          sahip_q, yaz_q, hata_q, bellek_yaz_q;
  logic [ADRES_BIT-1:0]          bellek_adres_q;
  logic [VERI_BIT-1:0]           bellek_yaz_veri_q;
  logic [1:0][VERI_BIT-1:0]      yanit_veri;
  logic [1:0]                    yanit_hata;

  assign istek = {bif.veri_istek, bif.getir_istek};
  assign talep[GETIR] = '{yaz: 1'b0, adres: bif.getir_adres, yaz_veri: '0};
  assign talep[VERI]  = '{yaz: bif.veri_yaz, adres: bif.veri_adres, yaz_veri: bif.veri_yaz_veri};

  for (genvar g = 0; g < 2; g++) begin : g_denetim
    bellek_hakemi_denetim #(
      .ADRES_BIT   (ADRES_BIT),
      .BELLEK_ADRES(BELLEK_ADRES),
      .BELLEK_BOYUT(BELLEK_BOYUT)
    ) u_denetim (
      .adres(talep[g].adres),
      .hata (hata[g])
    );
  end

  always_comb begin
    durum_sonraki = durum;
    sayac_sonraki = sayac;
    hazir         = '0;
    // veri wins by default; a starved getir wins once sayac reaches the limit.
    sahip = (istek[GETIR] && (!istek[VERI] || sayac == SINIR)) ? GETIR : VERI;
    kabul = (durum != ERISIM) && istek[sahip];
    case (durum)
      BOSTA:   if (kabul) durum_sonraki = ERISIM;
      ERISIM:  durum_sonraki = YANIT;
      YANIT:   durum_sonraki = kabul ? ERISIM : BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
    if (kabul) begin
      hazir[sahip]  = 1'b1;
      sayac_sonraki = (sahip == VERI && istek[GETIR]) ? sayac + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum             <= BOSTA;
      sayac             <= '0;
      sahip_q           <= GETIR;
      yaz_q             <= 1'b0;
      hata_q            <= 1'b0;
      bellek_yaz_q      <= 1'b0;
      bellek_adres_q    <= BELLEK_ADRES;
      bellek_yaz_veri_q <= '0;
      yanit_veri        <= '0;
      yanit_hata        <= '0;
    end else begin
      durum <= durum_sonraki;
      sayac <= sayac_sonraki;
      if (kabul) begin
        sahip_q           <= sahip;
        yaz_q             <= talep[sahip].yaz;
        hata_q            <= hata[sahip];
        bellek_adres_q    <= talep[sahip].adres;
        bellek_yaz_veri_q <= talep[sahip].yaz_veri;
        bellek_yaz_q      <= talep[sahip].yaz & ~hata[sahip];
      end else begin
        bellek_yaz_q <= 1'b0;
      end
      // Only the owner's response registers move, so the other side's data stays put.
      if (durum == ERISIM) begin
        yanit_veri[sahip_q] <= (!yaz_q && !hata_q) ? bif.bellek_oku_veri : '0;
        yanit_hata[sahip_q] <= hata_q;
      end
    end
  end

  assign bif.getir_hazir     = hazir[GETIR];
  assign bif.veri_hazir      = hazir[VERI];
  assign bif.getir_gecerli   = (durum == YANIT) && (sahip_q == GETIR);
  assign bif.veri_gecerli    = (durum == YANIT) && (sahip_q == VERI);
  assign bif.getir_veri      = yanit_veri[GETIR];
  assign bif.getir_hata      = yanit_hata[GETIR];
  assign bif.veri_oku_veri   = yanit_veri[VERI];
  assign bif.veri_hata       = yanit_hata[VERI];
  assign bif.bellek_adres    = bellek_adres_q;
  assign bif.bellek_yaz_veri = bellek_yaz_veri_q;
  // A store caught in flight by reset must not reach memory.
  assign bif.bellek_yaz      = bellek_yaz_q & ~rst;
endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: directed scenarios plus randomized traffic, checked each cycle
// against a transaction-level model (grant rule, 2-cycle cadence, reference memory image).
module tb_bellek_hakemi;
  localparam logic [31:0] BAZ   = 32'h8000_0000;
  localparam logic [31:0] UST   = 32'h8000_4000;
  localparam int          ACLIK = 4;

  typedef struct {
    bit          kim;   // 0 getir, 1 veri
    bit          yaz;
    bit          hata;
    logic [31:0] adres;
    logic [31:0] yveri;
    logic [31:0] veri;
    int          due;
  } tx_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bellek_hakemi_if #(.VERI_BIT(32), .ADRES_BIT(32)) bif ();

  bellek_hakemi #(
    .VERI_BIT(32), .ADRES_BIT(32), .BELLEK_ADRES(BAZ),
    .BELLEK_BOYUT(32'h0000_4000), .ACLIK_SINIRI(ACLIK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
  );

  // Memory seen by the DUT, and the bench's own reference image.
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  assign bif.bellek_oku_veri = mem[bif.bellek_adres[13:2]];
  always @(posedge clk) if (bif.bellek_yaz) mem[bif.bellek_adres[13:2]] = bif.bellek_yaz_veri;

  int testler = 0;
  int hatalar = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    testler++;
    if (gozlenen !== beklenen) begin
      hatalar++;
      $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  function automatic bit hata_f(input logic [31:0] a);
    return (a < BAZ) || (a >= UST) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rastgele_adres();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'h7FFF_FFFC;
    if (r == 1) return UST + 32'(4 * $urandom_range(0, 3));
    if (r <= 3) return BAZ + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
    return BAZ + 32'(4 * $urandom_range(0, 63));
  endfunction

  // Model state
  int    cyc = 0;
  int    son_kabul = -10;
  int    aclik = 0;
  bit    bekleyen = 0;
  tx_t   tx;
  string grants = "";
  int    nyaz = 0;

  // Last sampled outputs, for the directed checks
  logic        s_gh, s_vh, s_gg, s_vg, s_ghata, s_vhata, s_byaz;
  logic [31:0] s_gveri, s_vveri, s_badr, s_bwd;

  task automatic adim();
    bit e_gg, e_vg, e_yaz, e_gh, e_vh, drop_g, drop_v;
    drop_g = 0; drop_v = 0;
    @(negedge clk);
    s_gh = bif.getir_hazir;   s_vh = bif.veri_hazir;
    s_gg = bif.getir_gecerli; s_vg = bif.veri_gecerli;
    s_gveri = bif.getir_veri; s_vveri = bif.veri_oku_veri;
    s_ghata = bif.getir_hata; s_vhata = bif.veri_hata;
    s_byaz = bif.bellek_yaz;  s_badr = bif.bellek_adres; s_bwd = bif.bellek_yaz_veri;
    if (rst) begin
      kontrol("rst_bellek_yaz", 32'(s_byaz), 32'd0);
      bekleyen = 0; aclik = 0; son_kabul = -10;
    end else begin
      e_gg = bekleyen && tx.due == cyc && !tx.kim;
      e_vg = bekleyen && tx.due == cyc && tx.kim;
      kontrol("getir_gecerli", 32'(s_gg), 32'(e_gg));
      kontrol("veri_gecerli", 32'(s_vg), 32'(e_vg));
      if (e_gg) begin
        kontrol("getir_veri", s_gveri, tx.veri);
        kontrol("getir_hata", 32'(s_ghata), 32'(tx.hata));
      end
      if (e_vg) begin
        kontrol("veri_oku_veri", s_vveri, tx.veri);
        kontrol("veri_hata", 32'(s_vhata), 32'(tx.hata));
      end
      if (e_gg || e_vg) bekleyen = 0;
      e_yaz = 0;
      if (bekleyen && tx.due == cyc + 1) begin
        e_yaz = tx.yaz && !tx.hata;
        kontrol("bellek_adres", s_badr, tx.adres);
        if (e_yaz) begin
          kontrol("bellek_yaz_veri", s_bwd, tx.yveri);
          ref_mem[tx.adres[13:2]] = tx.yveri;
        end
        tx.veri = (tx.hata || tx.yaz) ? 32'd0 : ref_mem[tx.adres[13:2]];
      end
      kontrol("bellek_yaz", 32'(s_byaz), 32'(e_yaz));
      e_gh = 0; e_vh = 0;
      if (cyc != son_kabul + 1 && (bif.getir_istek || bif.veri_istek)) begin
        if (bif.veri_istek && !(bif.getir_istek && aclik == ACLIK)) e_vh = 1;
        else e_gh = 1;
      end
      kontrol("getir_hazir", 32'(s_gh), 32'(e_gh));
      kontrol("veri_hazir", 32'(s_vh), 32'(e_vh));
      if (e_gh || e_vh) begin
        tx.kim   = e_vh;
        tx.yaz   = e_vh && bif.veri_yaz;
        tx.adres = e_vh ? bif.veri_adres : bif.getir_adres;
        tx.yveri = bif.veri_yaz_veri;
        tx.hata  = hata_f(tx.adres);
        tx.veri  = 32'd0;
        tx.due   = cyc + 2;
        bekleyen = 1;
        son_kabul = cyc;
        aclik = (e_vh && bif.getir_istek) ? aclik + 1 : 0;
        drop_g = e_gh; drop_v = e_vh;
      end
    end
    if (s_gh) grants = {grants, "G"};
    if (s_vh) grants = {grants, "V"};
    if (s_byaz) nyaz++;
    @(posedge clk); #1;
    cyc++;
    if (drop_g) bif.getir_istek = 0;
    if (drop_v) bif.veri_istek = 0;
  endtask

  task automatic veri_ver(input bit yaz, input logic [31:0] adr, input logic [31:0] wd);
    bif.veri_istek = 1; bif.veri_yaz = yaz; bif.veri_adres = adr; bif.veri_yaz_veri = wd;
  endtask

  initial begin
    logic [31:0] v, eski;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    mem[0] = 32'h0000_0013; ref_mem[0] = 32'h0000_0013;
    rst = 1;
    bif.getir_istek = 0; bif.getir_adres = '0;
    bif.veri_istek = 0; bif.veri_yaz = 0; bif.veri_adres = '0; bif.veri_yaz_veri = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    kontrol("rst_hazir", {30'd0, bif.getir_hazir, bif.veri_hazir}, 32'd0);
    kontrol("rst_gecerli", {30'd0, bif.getir_gecerli, bif.veri_gecerli}, 32'd0);
    kontrol("rst_hata", {30'd0, bif.getir_hata, bif.veri_hata}, 32'd0);
    kontrol("rst_getir_veri", bif.getir_veri, 32'd0);
    kontrol("rst_veri_oku", bif.veri_oku_veri, 32'd0);
    kontrol("rst_bellek_adres", bif.bellek_adres, BAZ);
    kontrol("rst_bellek_yaz_veri", bif.bellek_yaz_veri, 32'd0);
    kontrol("rst_bellek_yaz", 32'(bif.bellek_yaz), 32'd0);
    @(posedge clk); #1;

    // 1: single fetch
    bif.getir_istek = 1; bif.getir_adres = BAZ;
    adim(); kontrol("t1_hazir", 32'(s_gh), 32'd1);
    adim(); kontrol("t1_adres", s_badr, BAZ);
    adim(); kontrol("t1_gecerli", 32'(s_gg), 32'd1);
    kontrol("t1_veri", s_gveri, 32'h0000_0013);
    kontrol("t1_vg", 32'(s_vg), 32'd0);
    adim();

    // 2: store then load to the same word
    nyaz = 0;
    veri_ver(1, 32'h8000_0100, 32'hDEAD_BEEF);
    repeat (3) adim();
    kontrol("t2_st_gecerli", 32'(s_vg), 32'd1);
    veri_ver(0, 32'h8000_0100, 32'h0);
    repeat (3) adim();
    kontrol("t2_ld_gecerli", 32'(s_vg), 32'd1);
    kontrol("t2_ld_veri", s_vveri, 32'hDEAD_BEEF);
    kontrol("t2_ld_hata", 32'(s_vhata), 32'd0);
    kontrol("t2_yaz_sayisi", 32'(nyaz), 32'd1);
    adim();

    // 4: misaligned store, below-base load
    nyaz = 0;
    veri_ver(1, 32'h8000_0102, 32'h1111_2222);
    repeat (3) adim();
    kontrol("t4_st_hata", 32'(s_vhata), 32'd1);
    veri_ver(0, 32'h7FFF_FFFC, 32'h0);
    repeat (3) adim();
    kontrol("t4_ld_hata", 32'(s_vhata), 32'd1);
    kontrol("t4_ld_veri", s_vveri, 32'd0);
    kontrol("t4_yaz_sayisi", 32'(nyaz), 32'd0);
    adim();

    // 5: reset during a store's memory cycle
    eski = ref_mem[32'h80];
    veri_ver(1, 32'h8000_0200, 32'h1234_5678);
    adim();
    rst = 1;
    adim();
    kontrol("t5_yaz_port", 32'(s_byaz), 32'd0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      adim();
      kontrol("t5_yanit_yok", 32'(s_vg), 32'd0);
    end
    kontrol("t5_adres", s_badr, BAZ);
    kontrol("t5_bellek", mem[32'h80], eski);

    // 6: fetch waiting behind a load gets granted in the load's response cycle
    veri_ver(0, 32'h8000_0040, 32'h0);
    adim();
    bif.getir_istek = 1; bif.getir_adres = 32'h8000_0008;
    adim(); kontrol("t6_erisim_hazir", 32'(s_gh), 32'd0);
    adim();
    kontrol("t6_getir_hazir", 32'(s_gh), 32'd1);
    kontrol("t6_veri_gecerli", 32'(s_vg), 32'd1);
    adim(); adim();
    kontrol("t6_getir_gecerli", 32'(s_gg), 32'd1);
    adim();

    // 3: both requesters held continuously
    grants = "";
    for (int i = 0; i < 24; i++) begin
      if (!bif.getir_istek) begin bif.getir_istek = 1; bif.getir_adres = BAZ + 32'(4 * $urandom_range(0, 63)); end
      if (!bif.veri_istek) veri_ver($urandom_range(0, 1), BAZ + 32'(4 * $urandom_range(0, 63)), $urandom);
      adim();
    end
    kontrol("t3_sira", (grants.substr(0, 9) == "VVVVGVVVVG") ? 32'd1 : 32'd0, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (!bif.getir_istek && $urandom_range(0, 2) == 0) begin
        bif.getir_istek = 1; bif.getir_adres = rastgele_adres();
      end
      if (!bif.veri_istek && $urandom_range(0, 2) == 0)
        veri_ver($urandom_range(0, 1), rastgele_adres(), $urandom);
      adim();
    end
    for (int i = 0; i < 10; i++) adim();

    $display("[TB] %0d tests run, %0d failed", testler, hatalar);
    $finish;
  end
endmodule
